// File: rtl/pipeline_hazard_controller.sv
// rtl/pipeline_hazard_controller.sv - pipeline hazard sequencer for the 5-stage SimpleRISC pipe
//
// Merges taken-branch flush, load-use stall, memory wait and halt into the
// PC write enable plus the four pipeline-latch enable/bubble controls.
//
// Optional build macro: PIPE_CTRL_STATS_EN adds saturating statistics counters.
//
// Ports:
//   clk, reset (sync, active-high)
//   is_branch_taken, load_use_hazard, mem_busy, halt_req : hazard events
//   pc_en, if_of_en, of_ex_en, ex_ma_en, ma_rw_en        : latch enables
//   flush        : squash IF/OF and OF/EX
//   of_ex_bubble : load NOP into OF/EX
//   halted       : controller in HALT
//   flush_cycles, stall_cycles, wait_cycles              : stats (macro only)
module pipeline_hazard_controller #(
  parameter int FLUSH_CYCLES = 3
`ifdef PIPE_CTRL_STATS_EN
  , parameter int CNT_W = 16
`endif
) (
  input  logic clk,
  input  logic reset,
  input  logic is_branch_taken,
  input  logic load_use_hazard,
  input  logic mem_busy,
  input  logic halt_req,
  output logic pc_en,
  output logic if_of_en,
  output logic of_ex_en,
  output logic ex_ma_en,
  output logic ma_rw_en,
  output logic flush,
  output logic of_ex_bubble,
  output logic halted
`ifdef PIPE_CTRL_STATS_EN
  , output logic [CNT_W-1:0] flush_cycles
  , output logic [CNT_W-1:0] stall_cycles
  , output logic [CNT_W-1:0] wait_cycles
`endif
);

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    FLUSH    = 2'd1,
    MEM_WAIT = 2'd2,
    HALT     = 2'd3
  } state_t;

  localparam logic [2:0] FCNT_LOAD = 3'(FLUSH_CYCLES - 1);

  state_t     state, next_state;
  logic [2:0] fcnt, next_fcnt;
  logic       resume_flush, next_resume_flush;  // 1: MEM_WAIT returns to FLUSH

  // State register
  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= RUN;
      fcnt         <= 3'd0;
      resume_flush <= 1'b0;
    end else begin
      state        <= next_state;
      fcnt         <= next_fcnt;
      resume_flush <= next_resume_flush;
    end
  end

  // Next-state logic
  always_comb begin
    next_state        = state;
    next_fcnt         = fcnt;
    next_resume_flush = resume_flush;
    case (state)
      RUN: begin
        if (halt_req) begin
          next_state = HALT;
        end else if (mem_busy) begin
          // A branch/hazard in this cycle is frozen in EX and re-presents later.
          next_state        = MEM_WAIT;
          next_resume_flush = 1'b0;
        end else if (is_branch_taken) begin
          if (FLUSH_CYCLES > 1) begin
            next_state = FLUSH;
            next_fcnt  = FCNT_LOAD;
          end
        end
      end
      FLUSH: begin
        if (halt_req) begin
          next_state = HALT;
        end else if (mem_busy) begin
          next_state        = MEM_WAIT;
          next_resume_flush = 1'b1;
        end else begin
          next_fcnt = fcnt - 3'd1;
          if (fcnt == 3'd1) next_state = RUN;
        end
      end
      MEM_WAIT: begin
        if (!mem_busy) next_state = resume_flush ? FLUSH : RUN;
      end
      HALT: begin
        next_state = HALT;
      end
      default: begin
        next_state = RUN;
      end
    endcase
  end

  // Output logic
  logic en_all;
  logic stall;

  always_comb begin
    en_all = 1'b1;
    stall  = 1'b0;
    flush  = 1'b0;
    halted = 1'b0;
    case (state)
      RUN: begin
        if (halt_req || mem_busy) begin
          en_all = 1'b0;
        end else if (is_branch_taken) begin
          flush = 1'b1;  // load-use is moot: that instruction is squashed
        end else if (load_use_hazard) begin
          stall = 1'b1;
        end
      end
      FLUSH: begin
        if (halt_req || mem_busy) en_all = 1'b0;
        else                      flush  = 1'b1;
      end
      MEM_WAIT: begin
        en_all = 1'b0;
      end
      HALT: begin
        en_all = 1'b0;
        halted = 1'b1;
      end
      default: begin
        en_all = 1'b0;
      end
    endcase
  end

  assign pc_en        = en_all & ~stall;
  assign if_of_en     = en_all & ~stall;
  assign of_ex_en     = en_all;
  assign ex_ma_en     = en_all;
  assign ma_rw_en     = en_all;
  assign of_ex_bubble = stall;

`ifdef PIPE_CTRL_STATS_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      flush_cycles <= '0;
      stall_cycles <= '0;
      wait_cycles  <= '0;
    end else if (state != HALT) begin
      if (flush && !(&flush_cycles))               flush_cycles <= flush_cycles + 1'b1;
      if (of_ex_bubble && !(&stall_cycles))        stall_cycles <= stall_cycles + 1'b1;
      if ((state == MEM_WAIT) && !(&wait_cycles))  wait_cycles  <= wait_cycles + 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_pipeline_hazard_controller.sv
// tb/tb_pipeline_hazard_controller.sv - scoreboard bench for pipeline_hazard_controller
module tb_pipeline_hazard_controller;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic is_branch_taken = 1'b0;
  logic load_use_hazard = 1'b0;
  logic mem_busy = 1'b0;
  logic halt_req = 1'b0;
  logic pc_en, if_of_en, of_ex_en, ex_ma_en, ma_rw_en, flush, of_ex_bubble, halted;
`ifdef PIPE_CTRL_STATS_EN
  logic [15:0] flush_cycles, stall_cycles, wait_cycles;
`endif

  always #5 clk = ~clk;

  pipeline_hazard_controller #(.FLUSH_CYCLES(3)) dut (
    .clk(clk), .reset(reset),
    .is_branch_taken(is_branch_taken), .load_use_hazard(load_use_hazard),
    .mem_busy(mem_busy), .halt_req(halt_req),
    .pc_en(pc_en), .if_of_en(if_of_en), .of_ex_en(of_ex_en),
    .ex_ma_en(ex_ma_en), .ma_rw_en(ma_rw_en),
    .flush(flush), .of_ex_bubble(of_ex_bubble), .halted(halted)
`ifdef PIPE_CTRL_STATS_EN
    , .flush_cycles(flush_cycles), .stall_cycles(stall_cycles), .wait_cycles(wait_cycles)
`endif
  );

  // {pc_en, if_of_en, of_ex_en, ex_ma_en, ma_rw_en, flush, of_ex_bubble, halted}
  localparam logic [7:0] RUNV = 8'b11111_0_0_0;
  localparam logic [7:0] FLV  = 8'b11111_1_0_0;
  localparam logic [7:0] STL  = 8'b00111_0_1_0;
  localparam logic [7:0] FRZ  = 8'b00000_0_0_0;
  localparam logic [7:0] HLT  = 8'b00000_0_0_1;

  typedef struct {
    logic [7:0] v;
    int         fc;    // expected flush_cycles, -1 = not checked
    string      name;
  } exp_t;

  exp_t sb[$];
  int   total = 0;
  int   bad = 0;

  // Monitor: compares mid-cycle, away from the active edge
  always @(negedge clk) begin
    if (sb.size() > 0) begin
      exp_t e;
      logic [7:0] got;
      e   = sb.pop_front();
      got = {pc_en, if_of_en, of_ex_en, ex_ma_en, ma_rw_en, flush, of_ex_bubble, halted};
      total++;
      if (got !== e.v) begin
        bad++;
        $display("FAIL %s: got=%b expected=%b", e.name, got, e.v);
      end
`ifdef PIPE_CTRL_STATS_EN
      if (e.fc >= 0) begin
        total++;
        if (flush_cycles !== 16'(e.fc)) begin
          bad++;
          $display("FAIL %s flush_cycles: got=%0d expected=%0d", e.name, flush_cycles, e.fc);
        end
      end
`endif
    end
  end

  task automatic step(input logic br, input logic luh, input logic mb, input logic hr,
                      input logic [7:0] ev, input string nm, input int fc = -1);
    exp_t e;
    @(posedge clk);
    #1;
    reset           = 1'b0;
    is_branch_taken = br;
    load_use_hazard = luh;
    mem_busy        = mb;
    halt_req        = hr;
    e.v = ev; e.fc = fc; e.name = nm;
    sb.push_back(e);
  endtask

  // Reset is sampled at the edge that starts the next step
  task automatic do_reset();
    @(posedge clk);
    #1;
    reset = 1'b1;
    is_branch_taken = 1'b0;
    load_use_hazard = 1'b0;
    mem_busy = 1'b0;
    halt_req = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // 1: reset then idle
    for (int i = 0; i < 5; i++) step(0, 0, 0, 0, RUNV, "idle");
    // 2: branch pulse, three flush cycles
    step(1, 0, 0, 0, FLV, "br_f1");
    step(0, 0, 0, 0, FLV, "br_f2");
    step(0, 0, 0, 0, FLV, "br_f3");
    step(0, 0, 0, 0, RUNV, "br_done", 3);
    // 3: load-use hazard for two cycles
    step(0, 1, 0, 0, STL, "luh1");
    step(0, 1, 0, 0, STL, "luh2");
    step(0, 0, 0, 0, RUNV, "luh_done");
    // 4: branch and hazard together
    step(1, 1, 0, 0, FLV, "brluh_f1");
    step(0, 1, 0, 0, FLV, "brluh_f2");
    step(0, 0, 0, 0, FLV, "brluh_f3");
    step(0, 0, 0, 0, RUNV, "brluh_done");
    // 5: memory wait interrupting the flush (fcnt frozen at 1)
    step(1, 0, 0, 0, FLV, "bw_f1");
    step(0, 0, 0, 0, FLV, "bw_f2");
    step(0, 0, 1, 0, FRZ, "bw_wait0");
    step(0, 0, 1, 0, FRZ, "bw_wait1");
    step(0, 0, 1, 0, FRZ, "bw_wait2");
    step(0, 0, 1, 0, FRZ, "bw_wait3");
    step(0, 0, 0, 0, FRZ, "bw_release");
    step(0, 0, 0, 0, FLV, "bw_f3");
    step(0, 0, 0, 0, RUNV, "bw_done");
    // mem_busy outranks a same-cycle branch; the branch re-presents afterwards
    step(1, 0, 1, 0, FRZ, "mbbr_freeze");
    step(0, 0, 0, 0, FRZ, "mbbr_release");
    step(1, 0, 0, 0, FLV, "mbbr_re_f1");
    // reset mid-flush
    do_reset();
    step(0, 0, 0, 0, RUNV, "rst_midflush");
    // 6: halt, branches ignored, reset exits
    step(0, 0, 0, 1, FRZ, "halt_req");
    step(1, 0, 0, 0, HLT, "halt_br");
    step(0, 1, 0, 0, HLT, "halt_luh");
    step(0, 0, 0, 0, HLT, "halt_idle");
    do_reset();
    step(0, 0, 0, 0, RUNV, "halt_reset");
    step(0, 0, 0, 0, RUNV, "post_reset");

    for (int i = 0; i < 20 && sb.size() > 0; i++) @(posedge clk);
    if (sb.size() != 0) begin
      bad++;
      $display("FAIL drain: got=%0d pending expected=0", sb.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
